// File: rtl/paged_mmu_pipe.sv
// Pipelined page-translation unit: a 2^IDX_W-entry page table written over the SR bus,
// cleared by a post-reset sweep, and a one-deep valid/ready response stage with fault counting.
module paged_mmu_pipe #(
  parameter int          VA_W    = 16,
  parameter int          PA_W    = 24,
  parameter int          IDX_W   = 4,
  parameter logic [15:0] SR_BASE = 16'h0100
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [VA_W-1:0] i_req_addr,
  input  logic            i_pag_en,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [PA_W-1:0] o_rsp_addr,
  output logic            o_rsp_cacheable,
  output logic            o_rsp_fault,
  input  logic [15:0]     i_sr_addr,
  input  logic [15:0]     i_sr_data,
  input  logic            i_sr_we,
  output logic            o_busy,
  output logic [7:0]      o_fault_cnt
);
  localparam int OFF_W   = VA_W - IDX_W;
  localparam int FRAME_W = PA_W - OFF_W;
  localparam int ENT_W   = FRAME_W + 2;
  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [15:0] ENT_MASK = 16'hC000 | 16'((1 << FRAME_W) - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [ENT_W-1:0]   tbl_q [ENTRIES];

  logic [15:0]        sr_off;
  logic               sr_hit;
  logic               sr_data_unused;
  logic [ENT_W-1:0]   ent;
  logic               acc;
  logic [PA_W-1:0]    xl_addr;
  logic               xl_c, xl_f;

  logic               rsp_valid_q, rsp_valid_d;
  logic [PA_W-1:0]    rsp_addr_q, rsp_addr_d;
  logic               rsp_c_q, rsp_c_d;
  logic               rsp_f_q, rsp_f_d;
  logic [7:0]         fault_cnt_q, fault_cnt_d;

  // Control FSM: sweep every entry once, then run until the next reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + IDX_W'(1);
      if (cnt_q == '1) state_q <= ST_RUN;
    end
  end

  // Table write port: the sweep owns it while clearing, so SR writes are dropped then.
  assign sr_off         = i_sr_addr - SR_BASE;
  assign sr_hit         = i_sr_we && (i_sr_addr >= SR_BASE) && (sr_off[15:IDX_W] == '0);
  assign sr_data_unused = ^(i_sr_data & ~ENT_MASK);

  always_ff @(posedge i_clk) begin
    if (state_q == ST_CLEAR) tbl_q[cnt_q] <= '0;
    else if (sr_hit)         tbl_q[sr_off[IDX_W-1:0]] <= {i_sr_data[15], i_sr_data[14], i_sr_data[FRAME_W-1:0]};
  end

  // Lookup reads the registered table, so a same-edge SR write is seen only by later requests.
  assign ent         = tbl_q[i_req_addr[VA_W-1 -: IDX_W]];
  assign o_req_ready = (state_q == ST_RUN) && (!rsp_valid_q || i_rsp_ready);
  assign acc         = i_req_valid && o_req_ready;

  always_comb begin
    xl_addr = '0;
    xl_c    = 1'b0;
    xl_f    = 1'b0;
    if (!i_pag_en) begin
      xl_addr = PA_W'(i_req_addr);
      xl_c    = 1'b1;
    end else if (ent[ENT_W-1]) begin
      xl_addr = {ent[FRAME_W-1:0], i_req_addr[OFF_W-1:0]};
      xl_c    = ent[ENT_W-2];
    end else begin
      xl_f    = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_c_d     = rsp_c_q;
    rsp_f_d     = rsp_f_q;
    fault_cnt_d = fault_cnt_q;
    if (acc) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = xl_addr;
      rsp_c_d     = xl_c;
      rsp_f_d     = xl_f;
      if (xl_f) fault_cnt_d = sat_inc8(fault_cnt_q);
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response stage: holds its payload until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_c_q     <= 1'b0;
      rsp_f_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_c_q     <= rsp_c_d;
      rsp_f_q     <= rsp_f_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign o_busy          = (state_q == ST_CLEAR);
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_addr      = rsp_addr_q;
  assign o_rsp_cacheable = rsp_c_q;
  assign o_rsp_fault     = rsp_f_q;
  assign o_fault_cnt     = fault_cnt_q;
endmodule

// File: tb/tb_paged_mmu_pipe.sv
// Bench for paged_mmu_pipe: directed scenarios plus random traffic against a transaction-level model.
module tb_paged_mmu_pipe;
  logic        clk = 1'b0;
  logic        rst, req_valid, pag_en, rsp_ready, sr_we;
  logic [15:0] req_addr, sr_addr, sr_data;
  logic        req_ready, rsp_valid, rsp_c, rsp_f, busy;
  logic [23:0] rsp_addr;
  logic [7:0]  fault_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level model of what the consumer should observe.
  bit          m_run;
  int          m_sweep;
  bit          m_valid, m_c, m_f;
  logic [23:0] m_addr;
  int          m_fcnt;
  logic [15:0] m_tbl [16];

  paged_mmu_pipe dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr), .i_pag_en(pag_en),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_addr(rsp_addr),
    .o_rsp_cacheable(rsp_c), .o_rsp_fault(rsp_f),
    .i_sr_addr(sr_addr), .i_sr_data(sr_data), .i_sr_we(sr_we),
    .o_busy(busy), .o_fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_sweep = 0; m_valid = 0; m_addr = '0; m_c = 0; m_f = 0; m_fcnt = 0;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic tick();
    bit exp_ready, acc;
    logic [15:0] e;
    #1;
    exp_ready = m_run && (!m_valid || rsp_ready);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      acc = req_valid && exp_ready;
      if (acc) begin
        e = m_tbl[req_addr >> 12];
        m_valid = 1;
        if (!pag_en) begin
          m_addr = 24'(req_addr); m_c = 1; m_f = 0;
        end else if (e[15]) begin
          m_addr = (24'(e & 16'h0FFF) << 12) | 24'(req_addr & 16'h0FFF); m_c = e[14]; m_f = 0;
        end else begin
          m_addr = '0; m_c = 0; m_f = 1;
          if (m_fcnt < 255) m_fcnt++;
        end
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      if (m_run && sr_we && sr_addr >= 16'h0100 && sr_addr < 16'h0110)
        m_tbl[sr_addr - 16'h0100] = sr_data;
      if (!m_run) begin
        m_sweep++;
        if (m_sweep == 16) begin
          m_run = 1;
          for (int k = 0; k < 16; k++) m_tbl[k] = '0;
        end
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(!m_run));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_addr", 32'(rsp_addr), 32'(m_addr));
    chk("rsp_cacheable", 32'(rsp_c), 32'(m_c));
    chk("rsp_fault", 32'(rsp_f), 32'(m_f));
    chk("fault_cnt", 32'(fault_cnt), 32'(m_fcnt));
    sr_we = 1'b0;
  endtask

  task automatic req(input bit v, input logic [15:0] va, input bit pg, input bit rr);
    req_valid = v; req_addr = va; pag_en = pg; rsp_ready = rr;
    tick();
  endtask

  task automatic sr_wr(input logic [15:0] a, input logic [15:0] d);
    sr_we = 1'b1; sr_addr = a; sr_data = d;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_addr = '0; pag_en = 0; rsp_ready = 1;
    sr_we = 0; sr_addr = '0; sr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    tick();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

    // Sweep: SR write and pending request are both ignored while busy.
    rst = 1'b0;
    sr_wr(16'h0102, 16'hC0AA);
    for (int i = 0; i < 16; i++) req(1, 16'h2000, 1, 1);
    chk("sweep_done_busy", 32'(busy), 32'd0);
    req(1, 16'h0000, 1, 1);
    chk("va0_fault", 32'(rsp_f), 32'd1);
    req(1, 16'hF000, 1, 1);
    req(1, 16'h2000, 1, 1);
    chk("sweep_dropped_sr", 32'(rsp_f), 32'd1);

    // Paging disabled.
    req(1, 16'hABCD, 0, 1);
    chk("nopage_addr", 32'(rsp_addr), 32'h00ABCD);

    // Table write then translated lookup.
    sr_wr(16'h0103, 16'hC123);
    req(0, 16'h0000, 1, 1);
    req(1, 16'h3456, 1, 0);
    chk("xl_addr", 32'(rsp_addr), 32'h123456);
    chk("xl_c", 32'(rsp_c), 32'd1);

    // Stall three cycles, then stream four.
    for (int i = 0; i < 3; i++) req(1, 16'hABCD, 0, 0);
    chk("stall_hold", 32'(rsp_addr), 32'h123456);
    for (int i = 0; i < 4; i++) req(1, 16'h3000 + 16'(i), 1, 1);
    chk("stream_last", 32'(rsp_addr), 32'h123003);

    // Read-before-write on the same edge.
    sr_wr(16'h0103, 16'h8777);
    req(1, 16'h3000, 1, 1);
    chk("rbw_old", 32'(rsp_addr), 32'h123000);
    req(1, 16'h3000, 1, 1);
    chk("rbw_new", 32'(rsp_addr), 32'h777000);
    chk("rbw_new_c", 32'(rsp_c), 32'd0);
    sr_wr(16'h0113, 16'hC555);
    req(1, 16'h3000, 1, 1);
    chk("out_of_range_sr", 32'(rsp_addr), 32'h777000);

    // Random traffic, including SR writes around the window edges.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 2) == 0) sr_wr(16'h00F8 + 16'($urandom_range(0, 31)), 16'($urandom));
      req($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Fault counter saturation.
    sr_wr(16'h0105, 16'h0000);
    req(0, 16'h0000, 1, 1);
    for (int i = 0; i < 300; i++) req(1, 16'h5000 | 16'($urandom_range(0, 4095)), 1, 1);
    chk("fault_sat", 32'(fault_cnt), 32'd255);

    // Reset while a response is stalled.
    req(1, 16'h1234, 0, 0);
    req(1, 16'h1234, 0, 0);
    rst = 1'b1;
    req(0, 16'h0000, 0, 0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_fcnt", 32'(fault_cnt), 32'd0);
    rst = 1'b0;
    sr_wr(16'h0105, 16'hC001);
    for (int i = 0; i < 16; i++) req(1, 16'h5000, 1, 1);
    req(1, 16'h5000, 1, 1);
    chk("post_rst_fault", 32'(rsp_f), 32'd1);
    chk("post_rst_fcnt", 32'(fault_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
